m_seq_checker: RTL and testbench
================================

# m_seq_checker

Receive-side counterpart of the SMA bit-stream transmitter. Takes the single-bit stream arriving on an SMA input, recovers bit timing at a fixed oversampling ratio, and self-synchronises an LFSR to the received maximum-length (m-) sequence. Once locked, it counts bit errors against the locally predicted sequence. Sits at the top level next to the transmitter path, fed from the SMA input pin.

## Interface
- `N`, 7, LFSR length in bits.
- `TAPS`, 7'b1100000, feedback mask (x^7+x^6+1). Bit i set means received bit k-1-i contributes to bit k.
- `BIT_DIV`, 50, clocks per bit (1 Mbit/s at 50 MHz); must be ≥ 4.
- `LOCK_CNT`, 32, consecutive correct predictions required to declare lock.
- `ERR_LIMIT`, 8, errors within one 64-bit window that force loss of lock.

- `CLK_50MHZ`  in  1  sole clock; all logic on its rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `SMA_IN`  in  1  asynchronous serial bit stream.
- `CLR_ERR`  in  1  synchronous clear of `err_count`.
- `bit_valid`  out  1  one-cycle strobe per recovered bit.
- `bit_out`  out  1  recovered bit; valid while `bit_valid`=1.
- `locked`  out  1  high in LOCKED state.
- `err_pulse`  out  1  one-cycle pulse per bit error while locked.
- `err_count`  out  16  saturating error total.

## Operation
- Input conditioning: `SMA_IN` passes through a 2-FF synchroniser to give `s`. A third FF holds `s_d`, and an edge is `s != s_d`.
- Bit timing uses a phase counter `ph` running 0..BIT_DIV-1.
  - On an edge, `ph` is set to 0.
  - Otherwise `ph` increments, wrapping BIT_DIV-1 → 0.
  - When `ph == BIT_DIV/2` (integer division), `bit_valid` is 1 for that cycle and `bit_out` = `s`.
  - Absence of edges (long runs) leaves the counter free-running at the nominal rate.
- Shift register `sr[N-1:0]` holds the received history, with `sr[0]` the newest bit.
  - Prediction `p` = XOR-reduce(`sr` & `TAPS`).
  - Every shift is `sr <= {sr[N-2:0], b}`.
- The state machine acts only on `bit_valid` cycles:
  - **SEED**: shift in the received bit and increment `fill`. When `fill` reaches N:
    - if the updated `sr` is nonzero, go to VERIFY with `match` = 0;
    - if `sr` is all-zero, stay in SEED with `fill` = 0.
  - **VERIFY**: compare the received bit with `p` and shift in the received bit.
    - Match: `match` increments. When `match` reaches LOCK_CNT, go to LOCKED and clear the window counters.
    - Mismatch: go to SEED with `fill` = 0. No `err_pulse` is generated.
  - **LOCKED**: flywheel operation, shifting in `p` rather than the received bit.
    - Mismatch: `err_pulse` = 1 for that cycle, `err_count` +1 (saturates at 0xFFFF), `win_err` +1.
    - `win_bits` counts 0..63. On wrap, `win_err` clears.
    - If `win_err` reaches ERR_LIMIT (including on the bit that produces the ERR_LIMIT-th error), go to SEED with `fill` = 0 and drop `locked` in the same transition.
- Error counter:
  - `CLR_ERR` zeroes `err_count`.
  - If `CLR_ERR` and an error occur in the same cycle, the result is 0: clear wins.
  - `err_count` is not cleared by loss of lock; only by reset or `CLR_ERR`.
- Reset: on `RST`=1 at a clock edge, the following are cleared: `sr`, `ph`, `fill`, `match`, `win_*`, `err_count`, sync FFs, and the state returns to SEED. All outputs are 0 the next cycle. Reset mid-bit or mid-lock discards all progress.

## Timing
- Latency from an `SMA_IN` change to edge detection: 3 clocks (2 sync + 1 compare).
- The first `bit_valid` after an edge occurs BIT_DIV/2 clocks after `ph` is zeroed, i.e. mid-bit.
- Consecutive `bit_valid` strobes are exactly BIT_DIV clocks apart without edges. An edge arriving within a bit period re-phases the strobe; at most one strobe occurs per phase pass.
- Outputs are registered:
  - `locked`, `err_pulse` and `err_count` update in the cycle following the `bit_valid` that caused them.
  - `err_pulse` is never asserted outside LOCKED.
- Minimum time to lock from reset with a clean stream: N + LOCK_CNT bits (39 bits = 1950 clocks at defaults), plus synchroniser/phase alignment of at most BIT_DIV + 3 clocks.

## Test plan
- Clean stream: drive the x^7+x^6+1 m-sequence at 50 clk/bit from reset. Required: `locked` rises after 39 bits, `err_count` stays 0 over 1000 bits, and `bit_valid` spacing is 50.
- Single flipped bit after lock: `err_pulse` is asserted exactly once, `err_count` = 1, and `locked` stays 1.
- Burst of 8 flipped bits inside one 64-bit window: `locked` drops after the 8th error, then re-locks within 39 further clean bits, and `err_count` = 8.
- All-zero input for 200 bits: `locked` never asserts and the state cycles within SEED.
- `CLR_ERR` in the same cycle as an error-producing strobe: `err_count` = 0. Separately, force 70000 errors: `err_count` saturates at 0xFFFF.
- `RST` asserted for 1 cycle while locked: the next cycle `locked`=0 and `err_count`=0, then re-lock after 39 bits.

Source files
------------

// File: rtl/m_seq_checker.sv
// Receive-side m-sequence checker: recovers bits from an oversampled serial input,
// self-synchronises an LFSR to the received sequence and counts bit errors once locked.
module m_seq_checker #(
    parameter int           N         = 7,
    parameter logic [N-1:0] TAPS      = 7'b1100000,
    parameter int           BIT_DIV   = 50,
    parameter int           LOCK_CNT  = 32,
    parameter int           ERR_LIMIT = 8,
    parameter int           ERR_W     = 16   // err_count saturates at 2**ERR_W-1, ERR_W <= 16
) (
    input  logic        CLK_50MHZ,
    input  logic        RST,
    input  logic        SMA_IN,
    input  logic        CLR_ERR,
    output logic        bit_valid,
    output logic        bit_out,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count
);

    localparam int PH_W    = $clog2(BIT_DIV);
    localparam int FILL_W  = $clog2(N + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WERR_W  = $clog2(ERR_LIMIT + 1);

    localparam logic [PH_W-1:0]    PH_LAST    = PH_W'(BIT_DIV - 1);
    localparam logic [PH_W-1:0]    PH_MID     = PH_W'(BIT_DIV / 2);
    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(N - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [WERR_W-1:0]  WERR_LIMIT = WERR_W'(ERR_LIMIT);
    localparam logic [5:0]         WIN_LAST   = 6'd63;

    typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    logic                sync_p0, s, s_d, edge_det;
    logic [PH_W-1:0]     ph;
    state_t              state, state_nx;
    logic [N-1:0]        sr, sr_nx, sr_rx;
    logic                pred, err_hit;
    logic [FILL_W-1:0]   fill, fill_nx;
    logic [MATCH_W-1:0]  match, match_nx;
    logic [5:0]          win_bits, win_bits_nx;
    logic [WERR_W-1:0]   win_err, win_err_nx, win_err_inc;
    logic [ERR_W-1:0]    err_cnt;

    // Input synchroniser and edge detect
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            sync_p0 <= 1'b0;
            s       <= 1'b0;
            s_d     <= 1'b0;
        end else begin
            sync_p0 <= SMA_IN;
            s       <= sync_p0;
            s_d     <= s;
        end
    end

    assign edge_det = s ^ s_d;

    // Bit timing recovery: phase restarts on every edge, strobe at mid-bit
    always_ff @(posedge CLK_50MHZ) begin
        if (RST || edge_det || ph == PH_LAST) ph <= '0;
        else                                  ph <= ph + PH_W'(1);
    end

    assign bit_valid = (ph == PH_MID);
    assign bit_out   = s;

    // Sequence tracking FSM
    assign pred  = ^(sr & TAPS);
    assign sr_rx = {sr[N-2:0], s};

    always_comb begin
        state_nx    = state;
        sr_nx       = sr;
        fill_nx     = fill;
        match_nx    = match;
        win_bits_nx = win_bits;
        win_err_nx  = win_err;
        win_err_inc = win_err;
        err_hit     = 1'b0;
        if (bit_valid) begin
            case (state)
                SEED: begin
                    sr_nx = sr_rx;
                    if (fill == FILL_LAST) begin
                        fill_nx = '0;
                        if (|sr_rx) begin
                            state_nx = VERIFY;
                            match_nx = '0;
                        end
                    end else begin
                        fill_nx = fill + FILL_W'(1);
                    end
                end
                VERIFY: begin
                    sr_nx = sr_rx;
                    if (s == pred) begin
                        match_nx = match + MATCH_W'(1);
                        if (match == MATCH_LAST) begin
                            state_nx    = LOCKED;
                            win_bits_nx = '0;
                            win_err_nx  = '0;
                        end
                    end else begin
                        state_nx = SEED;
                        fill_nx  = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the local prediction, not the received bit, feeds the LFSR
                    sr_nx       = {sr[N-2:0], pred};
                    err_hit     = (s != pred);
                    win_err_inc = win_err + WERR_W'(err_hit);
                    win_bits_nx = win_bits + 6'd1;
                    if (win_err_inc == WERR_LIMIT) begin
                        state_nx = SEED;
                        fill_nx  = '0;
                    end else if (win_bits == WIN_LAST) begin
                        win_err_nx = '0;
                    end else begin
                        win_err_nx = win_err_inc;
                    end
                end
                default: state_nx = SEED;
            endcase
        end
    end

    // Registered state and outputs
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state     <= SEED;
            sr        <= '0;
            fill      <= '0;
            match     <= '0;
            win_bits  <= '0;
            win_err   <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nx;
            sr        <= sr_nx;
            fill      <= fill_nx;
            match     <= match_nx;
            win_bits  <= win_bits_nx;
            win_err   <= win_err_nx;
            err_pulse <= err_hit;
            if (CLR_ERR)      err_cnt <= '0;
            else if (err_hit) err_cnt <= sat_inc(err_cnt);
        end
    end

    assign locked    = (state == LOCKED);
    assign err_count = 16'(err_cnt);

endmodule

// File: tb/tb_m_seq_checker.sv
// Bench for m_seq_checker: drives x^7+x^6+1 streams with planted bit flips and checks
// recovered bits through a scoreboard plus lock/error behaviour from a vector table.
module tb_m_seq_checker;

    localparam int BIT_DIV   = 8;
    localparam int LOCK_BITS = 39;
    localparam int ERR_LIMIT = 8;
    localparam int ERR_MAX   = 15;

    logic        CLK_50MHZ = 1'b0;
    logic        RST       = 1'b0;
    logic        SMA_IN    = 1'b0;
    logic        CLR_ERR   = 1'b0;
    logic        bit_valid, bit_out, locked, err_pulse;
    logic [15:0] err_count;

    m_seq_checker #(
        .N(7), .TAPS(7'b1100000), .BIT_DIV(BIT_DIV), .LOCK_CNT(32),
        .ERR_LIMIT(ERR_LIMIT), .ERR_W(4)
    ) dut (
        .CLK_50MHZ(CLK_50MHZ), .RST(RST), .SMA_IN(SMA_IN), .CLR_ERR(CLR_ERR),
        .bit_valid(bit_valid), .bit_out(bit_out), .locked(locked),
        .err_pulse(err_pulse), .err_count(err_count)
    );

    always #5 CLK_50MHZ = ~CLK_50MHZ;

    typedef struct {
        int pre;
        int flips;
        bit clr_last;
        int tail;
        int exp_pulses;
        int exp_errs;
        bit exp_locked;
        int exp_drops;
    } vec_t;

    int     n_cmp = 0, n_fail = 0;
    logic   sb[$];
    int     strobe_cnt, pulse_cnt, drop_cnt, lock_seen, since_rst;
    longint cyc = 0, last_strobe = 0;
    logic   prev_locked = 1'b0, mon_en = 1'b0;
    logic [6:0] hist;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK_50MHZ);
        #1;
    endtask

    task automatic monitor();
        logic exp;
        forever begin
            @(negedge CLK_50MHZ);
            cyc++;
            if (RST) begin
                since_rst   = 0;
                prev_locked = 1'b0;
            end else if (mon_en) begin
                if (bit_valid) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL sb_pop: strobe with empty queue, got bit %0d, expected none", bit_out);
                    end else begin
                        exp = sb.pop_front();
                        check("bit_out", bit_out, exp);
                    end
                    if (since_rst >= 10) check("spacing", cyc - last_strobe, BIT_DIV);
                    last_strobe = cyc;
                    since_rst++;
                    strobe_cnt++;
                end
                if (err_pulse) pulse_cnt++;
                if (locked) lock_seen++;
                if (prev_locked && !locked) drop_cnt++;
                prev_locked = locked;
            end
        end
    endtask

    task automatic gen(output logic b);
        b    = hist[5] ^ hist[6];
        hist = {hist[5:0], b};
    endtask

    task automatic send_bit(input logic b, input logic clr);
        SMA_IN  = b;
        CLR_ERR = clr;
        sb.push_back(b);
        repeat (BIT_DIV) step();
        CLR_ERR = 1'b0;
    endtask

    task automatic send_seq(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen(b);
            send_bit(b, 1'b0);
        end
    endtask

    task automatic send_flip(input logic clr);
        logic b;
        gen(b);
        send_bit(~b, clr);
    endtask

    task automatic do_reset(input logic [6:0] seed);
        RST     = 1'b1;
        SMA_IN  = 1'b0;
        CLR_ERR = 1'b0;
        step();
        check("rst_locked", locked, 0);
        check("rst_err_count", err_count, 0);
        check("rst_bit_valid", bit_valid, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_bit_out", bit_out, 0);
        sb.delete();
        hist       = seed;
        strobe_cnt = 0;
        pulse_cnt  = 0;
        drop_cnt   = 0;
        lock_seen  = 0;
        mon_en     = 1'b1;
        RST        = 1'b0;
    endtask

    task automatic lock_up();
        send_seq(LOCK_BITS - 1);
        check("prelock", locked, 0);
        send_seq(1);
        check("lock", locked, 1);
        check("lock_errs", err_count, 0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{5,  1, 1'b0, 20, 1, 1, 1'b1, 0};
        vecs[1] = '{0,  3, 1'b0, 10, 3, 3, 1'b1, 0};
        vecs[2] = '{10, 7, 1'b0, 30, 7, 7, 1'b1, 0};
        vecs[3] = '{3,  8, 1'b0, 39, 8, 8, 1'b1, 1};
        vecs[4] = '{3,  8, 1'b0, 38, 8, 8, 1'b0, 1};
        vecs[5] = '{4,  2, 1'b1, 10, 2, 0, 1'b1, 0};

        fork
            monitor();
        join_none

        // Clean stream: lock after 39 bits, then 1000 error-free bits
        do_reset(7'h01);
        lock_up();
        send_seq(1000);
        check("clean_pulses", pulse_cnt, 0);
        check("clean_errs", err_count, 0);
        check("clean_drops", drop_cnt, 0);
        check("clean_locked", locked, 1);
        check("clean_strobes", strobe_cnt, LOCK_BITS + 1000);
        check("clean_sb_drain", sb.size(), 0);

        // Flip patterns after lock
        for (int i = 0; i < 6; i++) begin
            do_reset(7'(i * 13 + 5));
            lock_up();
            send_seq(vecs[i].pre);
            for (int k = 1; k <= vecs[i].flips; k++) begin
                send_flip(vecs[i].clr_last && k == vecs[i].flips);
                check($sformatf("v%0d_flip%0d_locked", i, k), locked, k < ERR_LIMIT);
            end
            send_seq(vecs[i].tail);
            check($sformatf("v%0d_pulses", i), pulse_cnt, vecs[i].exp_pulses);
            check($sformatf("v%0d_errs", i), err_count, vecs[i].exp_errs);
            check($sformatf("v%0d_locked", i), locked, vecs[i].exp_locked);
            check($sformatf("v%0d_drops", i), drop_cnt, vecs[i].exp_drops);
            check($sformatf("v%0d_sb_drain", i), sb.size(), 0);
        end

        // All-zero input never locks
        do_reset(7'h11);
        for (int i = 0; i < 200; i++) send_bit(1'b0, 1'b0);
        check("zero_lock_seen", lock_seen, 0);
        check("zero_pulses", pulse_cnt, 0);
        check("zero_strobes", strobe_cnt, 200);
        check("zero_sb_drain", sb.size(), 0);

        // Saturation: 7 errors in each of three 64-bit windows keeps lock
        do_reset(7'h55);
        lock_up();
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < ERR_LIMIT - 1; k++) send_flip(1'b0);
            send_seq(64 - (ERR_LIMIT - 1));
            if (c == 0) check("sat_first_window", err_count, ERR_LIMIT - 1);
        end
        check("sat_errs", err_count, ERR_MAX);
        check("sat_pulses", pulse_cnt, 3 * (ERR_LIMIT - 1));
        check("sat_locked", locked, 1);
        check("sat_drops", drop_cnt, 0);
        begin
            logic b;
            gen(b);
            send_bit(b, 1'b1);
        end
        check("clr_alone", err_count, 0);

        // One-cycle reset while locked with errors pending, then re-lock
        do_reset(7'h2A);
        lock_up();
        send_flip(1'b0);
        send_flip(1'b0);
        check("pre_rst_errs", err_count, 2);
        check("pre_rst_locked", locked, 1);
        do_reset(7'h63);
        lock_up();
        check("relock_sb_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
